// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: scheduler state encodings and timer sizing shared by the TX scheduler files
package tx_sched_pkg;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    ISSUE     = ST_ISSUE,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE,
    GAP       = ST_GAP
  } state_e;
  function automatic int timer_width(input int busy_to, input int gap);
    return $clog2((busy_to > gap ? busy_to : gap) + 1);
  endfunction
endpackage

// File: rtl/tx_sched_timer.sv
// tx_sched_timer: clear/increment counter with a terminal-count compare
module tx_sched_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic         hit_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 1'b1;
  assign hit_o = cnt_q == term_i;
endmodule

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: drains FIFO words into UART_TX one frame at a time with busy watchdog and gap
module tx_frame_scheduler
  import tx_sched_pkg::*;
#(
  parameter int FRAME_WIDTH  = 8,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   ERR_CLR,
  input  logic                   FIFO_EMPTY,
  input  logic [FRAME_WIDTH-1:0] FIFO_RD_DATA,
  output logic                   FIFO_RD_INC,
  input  logic                   TX_BUSY,
  output logic [FRAME_WIDTH-1:0] TX_P_DATA,
  output logic                   TX_DATA_VALID,
  output logic                   SCHED_BUSY,
  output logic                   TIMEOUT_ERR,
  output logic [CNT_WIDTH-1:0]   FRAMES_SENT
);
  localparam int TW = timer_width(BUSY_TIMEOUT, GAP_CYCLES);
  localparam logic [TW-1:0] BUSY_T = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_T  = TW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_e state_q, state_d;
  logic [FRAME_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic err_q, err_d;
  logic cap, cnt_inc, tmr_clr, tmr_inc, tmr_hit;
  // one timer serves both the busy watchdog and the inter-frame gap
  tx_sched_timer #(.W(TW)) u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .clr_i (tmr_clr),
    .inc_i (tmr_inc),
    .term_i(state_q == GAP ? GAP_T : BUSY_T),
    .hit_o (tmr_hit)
  );
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    cnt_inc = 1'b0;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    err_d   = err_q & ~ERR_CLR;
    case (state_q)
      IDLE: if (EN && !FIFO_EMPTY) begin
        cap     = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        tmr_clr = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (TX_BUSY) state_d = WAIT_DONE;
      else if (tmr_hit) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else tmr_inc = 1'b1;
      WAIT_DONE: if (!TX_BUSY) begin
        cnt_inc = 1'b1;
        tmr_clr = 1'b1;
        state_d = GAP_CYCLES > 0 ? GAP : IDLE;
      end
      GAP: begin
        tmr_inc = 1'b1;
        state_d = tmr_hit ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (cap) data_q <= FIFO_RD_DATA;
      if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  assign TX_DATA_VALID = state_q == ISSUE;
  assign FIFO_RD_INC   = state_q == ISSUE;
  assign SCHED_BUSY    = state_q != IDLE;
  assign TX_P_DATA     = data_q;
  assign TIMEOUT_ERR   = err_q;
  assign FRAMES_SENT   = cnt_q;
endmodule
